// File: rtl/decode_stage_if.sv
// Handshake bus for the decode stage: upstream fetch side in, decoded entry out.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     instr_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [31:0]     out_instr_o;
  logic [4:0]      out_rd_o;
  logic [4:0]      out_rs1_o;
  logic [4:0]      out_rs2_o;
  logic [2:0]      out_funct3_o;
  logic [6:0]      out_funct7_o;
  logic [2:0]      out_imm_type_o;
  logic [XLEN-1:0] out_imm_o;
  logic            out_rd_we_o;
  logic            out_illegal_o;

  modport slave (
    input  in_valid_i, pc_i, instr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_rd_o, out_rs1_o,
           out_rs2_o, out_funct3_o, out_funct7_o, out_imm_type_o, out_imm_o,
           out_rd_we_o, out_illegal_o
  );

  modport master (
    output in_valid_i, pc_i, instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_rd_o, out_rs1_o,
           out_rs2_o, out_funct3_o, out_funct7_o, out_imm_type_o, out_imm_o,
           out_rd_we_o, out_illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// RISC-V decode stage: decodes at push time and buffers entries in a
// single register (DEPTH=1) or a two-entry skid buffer (DEPTH=2).
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  decode_stage_if.slave bus
);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      imm_type;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            illegal;
  } entry_t;

  function automatic entry_t decode(input logic [XLEN-1:0] pc, input logic [31:0] instr);
    entry_t                 e;
    logic [6:0]             opcode;
    logic                   legal;
    logic signed [31:0]     imm32;
    logic signed [XLEN-1:0] imm_x;
    opcode = instr[6:0];
    e      = '0;
    case (opcode)
      7'b0100011: begin
        e.imm_type = IMM_S;
        imm32      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        e.imm_type = IMM_B;
        imm32      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        e.imm_type = IMM_U;
        imm32      = {instr[31:12], 12'b0};
      end
      7'b1101111: begin
        e.imm_type = IMM_J;
        imm32      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        e.imm_type = IMM_I;
        imm32      = {{20{instr[31]}}, instr[31:20]};
      end
    endcase
    // signed-to-signed assignment replicates instr[31] up to XLEN
    imm_x = imm32;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011: legal = 1'b1;
      7'b0011011, 7'b0111011: legal = (XLEN == 64);
      default:                legal = 1'b0;
    endcase
    e.illegal = !legal || (instr[1:0] != 2'b11) || (instr == 32'h0) || (instr == 32'hFFFF_FFFF);
    e.pc      = pc;
    e.instr   = instr;
    e.rd      = instr[11:7];
    e.rs1     = instr[19:15];
    e.rs2     = instr[24:20];
    e.funct3  = instr[14:12];
    e.funct7  = instr[31:25];
    e.imm     = imm_x;
    e.rd_we   = !(e.illegal || opcode == 7'b0100011 || opcode == 7'b1100011 || e.rd == 5'd0);
    return e;
  endfunction

  function automatic logic next_ptr(input logic p);
    return (DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  entry_t     dec_p0;
  entry_t     mem_p1 [2];
  entry_t     head_p1;
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  logic       rst_done;
  logic       push, pop;

  // ---- stage 0: combinational decode of the incoming word
  assign dec_p0 = decode(bus.pc_i, bus.instr_i);

  always_comb begin
    if (DEPTH == 1) bus.in_ready_o = rst_done && ((count == 2'd0) || bus.out_ready_i);
    else            bus.in_ready_o = rst_done && (count != 2'd2);
  end

  assign push = bus.in_valid_i && bus.in_ready_o;
  assign pop  = bus.out_valid_o && bus.out_ready_i;

  // ---- stage 1: buffered decoded entries; flush overrides push and pop
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      rst_done  <= 1'b0;
      mem_p1[0] <= '0;
      mem_p1[1] <= '0;
    end else begin
      rst_done <= 1'b1;
      if (flush_i) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem_p1[wr_ptr] <= dec_p0;
          wr_ptr         <= next_ptr(wr_ptr);
        end
        if (pop) rd_ptr <= next_ptr(rd_ptr);
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign head_p1            = mem_p1[rd_ptr];
  assign bus.out_valid_o    = (count != 2'd0);
  assign bus.out_pc_o       = head_p1.pc;
  assign bus.out_instr_o    = head_p1.instr;
  assign bus.out_rd_o       = head_p1.rd;
  assign bus.out_rs1_o      = head_p1.rs1;
  assign bus.out_rs2_o      = head_p1.rs2;
  assign bus.out_funct3_o   = head_p1.funct3;
  assign bus.out_funct7_o   = head_p1.funct7;
  assign bus.out_imm_type_o = head_p1.imm_type;
  assign bus.out_imm_o      = head_p1.imm;
  assign bus.out_rd_we_o    = head_p1.rd_we;
  assign bus.out_illegal_o  = head_p1.illegal;

endmodule
